// File: rtl/bin_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : bin_decoder_if
// Purpose  : Enable/index request and registered one-hot result of bin_decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface bin_decoder_if #(
    parameter int IN  = 3,
    parameter int OUT = 1 << IN
) ();
    logic           en;
    logic [IN-1:0]  in;
    logic [OUT-1:0] out;
    logic           valid;

    modport master (output en, output in, input  out, input  valid);
    modport slave  (input  en, input  in, output out, output valid);
endinterface
`default_nettype wire

// File: rtl/bin_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bin_decoder
// Purpose  : Registered binary-to-one-hot (ACT=1) or one-cold (ACT=0) decoder.
// Revision : 1.0 - initial release
// ============================================================================
module bin_decoder #(
    parameter int   IN  = 3,
    parameter int   OUT = 1 << IN,
    parameter logic ACT = 1'b1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    bin_decoder_if.slave  bus
);

    localparam logic [OUT-1:0] C_IDLE = {OUT{~ACT}};

    logic [OUT-1:0] w_match;
    logic [OUT-1:0] out_d;
    logic [OUT-1:0] out_q;
    logic           valid_d;
    logic           valid_q;

    // Each output bit compares against its own index constant, bit 0 <-> in == 0.
    for (genvar k = 0; k < OUT; k++) begin : g_bit
        assign w_match[k] = (bus.in == IN'(k));
    end

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (bus.en) begin
            out_d   = ACT ? w_match : ~w_match;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= C_IDLE;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;

`ifndef SYNTHESIS
    a_in_known: assert property (@(posedge clk) disable iff (reset)
        bus.en |-> !$isunknown(bus.in));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_decoder
// Purpose  : Randomised and directed checks of bin_decoder for four parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [3:0] stim_in = '0;
    int         checks = 0;
    int         errors = 0;

    // Reference: just "is something captured" and "which index".
    logic       m_valid = 1'b0;
    logic [3:0] m_idx = '0;

    always #5 clk = ~clk;

    bin_decoder_if #(.IN(3)) if3h ();
    bin_decoder_if #(.IN(3)) if3l ();
    bin_decoder_if #(.IN(4)) if4h ();
    bin_decoder_if #(.IN(1)) if1h ();

    assign if3h.en = en;  assign if3h.in = stim_in[2:0];
    assign if3l.en = en;  assign if3l.in = stim_in[2:0];
    assign if4h.en = en;  assign if4h.in = stim_in;
    assign if1h.en = en;  assign if1h.in = stim_in[0];

    bin_decoder #(.IN(3), .ACT(1'b1)) u3h (.clk(clk), .reset(reset), .bus(if3h.slave));
    bin_decoder #(.IN(3), .ACT(1'b0)) u3l (.clk(clk), .reset(reset), .bus(if3l.slave));
    bin_decoder #(.IN(4), .ACT(1'b1)) u4h (.clk(clk), .reset(reset), .bus(if4h.slave));
    bin_decoder #(.IN(1), .ACT(1'b1)) u1h (.clk(clk), .reset(reset), .bus(if1h.slave));

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
        end else if (en) begin
            m_valid <= 1'b1;
            m_idx   <= stim_in;
        end
    end

    function automatic logic [15:0] model_out(input int n, input bit act, input bit v,
                                              input logic [3:0] idx);
        logic [15:0] r;
        int          sel;
        r   = '0;
        sel = int'(idx) % (1 << n);
        for (int k = 0; k < (1 << n); k++)
            r[k] = (v && k == sel) ? act : !act;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act_v, input logic [15:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act_v, exp_v);
        end
    endtask

    always @(negedge clk) begin
        chk("out3h",   16'(if3h.out),   model_out(3, 1'b1, m_valid, m_idx));
        chk("out3l",   16'(if3l.out),   model_out(3, 1'b0, m_valid, m_idx));
        chk("out4h",   16'(if4h.out),   model_out(4, 1'b1, m_valid, m_idx));
        chk("out1h",   16'(if1h.out),   model_out(1, 1'b1, m_valid, m_idx));
        chk("valid3h", 16'(if3h.valid), 16'(m_valid));
        chk("valid3l", 16'(if3l.valid), 16'(m_valid));
        chk("valid4h", 16'(if4h.valid), 16'(m_valid));
        chk("valid1h", 16'(if1h.valid), 16'(m_valid));
    end

    task automatic step(input logic e, input logic [3:0] v);
        @(negedge clk);
        en      = e;
        stim_in = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] hi_tab [8];
        logic [7:0] lo_tab [8];
        hi_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        lo_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out3h", 16'(if3h.out), 16'h0000);
        chk("rst_out3l", 16'(if3l.out), 16'h00FF);
        chk("rst_valid", 16'(if3h.valid), 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Idle after release: no en, outputs keep reset values.
        step(1'b0, 4'd3);
        chk("idle_out3h", 16'(if3h.out), 16'h0000);

        for (int k = 0; k < 8; k++) begin
            step(1'b1, 4'(k));
            chk("sweep_hi", 16'(if3h.out), 16'(hi_tab[k]));
            chk("sweep_lo", 16'(if3l.out), 16'(lo_tab[k]));
            chk("sweep_v",  16'(if3h.valid), 16'h0001);
        end
        chk("in1_is1", 16'(if1h.out), 16'h0002);
        step(1'b1, 4'd0);
        chk("in1_is0", 16'(if1h.out), 16'h0001);

        step(1'b1, 4'd5);
        chk("hold_pre", 16'(if3h.out), 16'h0020);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'd2);
            chk("hold_out", 16'(if3h.out), 16'h0020);
            chk("hold_v",   16'(if3h.valid), 16'h0001);
        end
        step(1'b1, 4'd2);
        chk("hold_rel", 16'(if3h.out), 16'h0004);

        step(1'b1, 4'd15);
        chk("wrap_msb", 16'(if4h.out), 16'h8000);
        step(1'b1, 4'd0);
        chk("wrap_lsb", 16'(if4h.out), 16'h0001);

        // Asynchronous reset mid-cycle, sampled before any further edge.
        step(1'b1, 4'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("async_hi", 16'(if3h.out), 16'h0000);
        chk("async_lo", 16'(if3l.out), 16'h00FF);
        chk("async_v",  16'(if3h.valid), 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Reset rising together with an enabled edge must win.
        @(negedge clk);
        en      = 1'b1;
        stim_in = 4'd6;
        #4;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("coll_hi", 16'(if3h.out), 16'h0000);
        chk("coll_lo", 16'(if3l.out), 16'h00FF);
        chk("coll_v",  16'(if3h.valid), 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        step(1'b1, 4'd3);
        chk("coll_rel", 16'(if3h.out), 16'h0008);

        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            en      = ($urandom_range(0, 3) != 0);
            stim_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                #2;
                reset = 1'b1;
                #3;
                reset = 1'b0;
            end
        end
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin_decoder.md
Name: bin_decoder

Overview:
- Parameterised binary-to-one-hot decoder with a registered output.
- Converts an IN-bit binary index into a 2^IN-bit vector: exactly one bit, at the index position, is driven to the active level ACT; all other bits are driven to ~ACT.
- Used as a generic select/enable generator for register files, bank selects and arbiter grants.

Parameters:
- IN, default 3: width of the binary input; must be >= 1.
- OUT, default 1 << IN: width of the decoded output. Derived; must not be overridden to any other value.
- ACT, default 1 (High): active level of the selected output bit. ACT=1 gives one-hot; ACT=0 gives one-cold.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- en, input, 1: decode enable. When 1, the in value is captured on the next clock edge.
- in, input, IN: binary index to decode.
- out, output, OUT: decoded vector (registered).
- valid, output, 1: high when out holds a decode of a captured index.

Behaviour:
- Reset, asserted asynchronously:
  - out = all bits ~ACT (all 0 for ACT=1, all 1 for ACT=0).
  - valid = 0.
  - Takes effect immediately, without waiting for a clock edge.
- Reset deasserted:
  - Outputs hold their reset values until the first rising edge of clk with en=1.
- Rising edge with reset=0 and en=1:
  - out[k] = ACT for k == in; out[k] = ~ACT for every other k.
  - valid = 1.
- Rising edge with reset=0 and en=0:
  - out and valid hold their previous values.
- Latency: exactly one clock from the in/en sample to the out update. out has no combinational path from in.
- Index range and bit order:
  - Every IN-bit value selects a valid output, since OUT = 2^IN and there is no out-of-range case.
  - Bit 0 corresponds to in = 0; bit OUT-1 corresponds to in = all-ones.
- Invariant: whenever valid = 1, exactly one bit of out equals ACT. When valid = 0, no bit equals ACT.
- Wrap-around: stepping in from OUT-1 to 0 moves the active bit from the MSB to the LSB, with no special handling.
- Reset mid-operation: reset asserted at any time (including coincident with en=1 and a clock edge) wins. Outputs return to the reset values immediately.
- Unknown input: X on in while en=1 need not be handled specially. Sim-only assertion flags it.
- Implementation: purely synchronous except the asynchronous reset. No latches.

Test Plan:
- Reset, IN=3, ACT=1: assert reset mid-cycle -> out=8'h00, valid=0 immediately, before any clock edge. Same with ACT=0 -> out=8'hFF.
- Sweep, IN=3, ACT=1, en=1: in=0..7 one per clock -> one cycle later out = 01, 02, 04, 08, 10, 20, 40, 80 (hex); out[in]==1 and popcount==1 each cycle; valid=1.
- Sweep, IN=3, ACT=0: same stimulus -> out = FE, FD, FB, F7, EF, DF, BF, 7F; out[in]==0 and exactly one zero bit.
- Hold: decode in=5 (out=8'h20), then en=0 and in=2 for 3 clocks -> out stays 8'h20, valid stays 1. Then en=1 -> out=8'h04 next cycle.
- Wrap and width: IN=4, ACT=1, in=15 then 0 -> out=16'h8000 then 16'h0001. IN=1 -> in=0 gives 2'b01, in=1 gives 2'b10.
- Reset collision: en=1, in=6, reset asserted on the same edge -> out=all ~ACT, valid=0. First en=1 edge after release decodes normally.
